sine_meas: RTL and testbench

Waveform measurement block that sits downstream of the sine generator and recovers its settings from the two sample streams it produces. It detects rising mid-scale crossings on both channels and counts samples between them. From the crossings it reports the channel-1 period and the channel-1-to-channel-2 lag. Its output is used to check increment and phase-offset settings in hardware without a scope.

---
 rtl/sine_meas.sv | 105 ++++++++++
 tb/tb_sine_meas.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sine_meas.sv
// Recovers period and channel-1-to-channel-2 lag from two sampled sine streams
// by counting qualified samples between rising mid-scale crossings.
module sine_meas #(
   parameter int D_WIDTH = 8,
   parameter int C_WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [D_WIDTH-1:0] din1,
   input  logic [D_WIDTH-1:0] din2,
   output logic [C_WIDTH-1:0] period,
   output logic [C_WIDTH-1:0] lag,
   output logic               meas_valid,
   output logic               lag_valid,
   output logic               timeout
);
   localparam logic [D_WIDTH-1:0] MID      = {1'b1, {(D_WIDTH-1){1'b0}}};
   localparam logic [C_WIDTH-1:0] CNT_LAST = ~C_WIDTH'(1);
   localparam logic [C_WIDTH-1:0] ONE      = C_WIDTH'(1);

   typedef enum logic {IDLE, ARMED} state_t;

   state_t             state, state_nx;
   logic [C_WIDTH-1:0] cnt, cnt_nx, lag_cap, lag_cap_nx;
   logic               lag_seen, lag_seen_nx;
   logic [D_WIDTH-1:0] prev1, prev2, prev1_nx, prev2_nx;
   logic [C_WIDTH-1:0] period_nx, lag_nx;
   logic               lag_valid_nx, meas_valid_nx, timeout_nx;
   logic               x1, x2;

   assign x1 = en && (prev1 < MID) && (din1 >= MID);
   assign x2 = en && (prev2 < MID) && (din2 >= MID);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         lag_cap    <= '0;
         lag_seen   <= 1'b0;
         prev1      <= '1;
         prev2      <= '1;
         period     <= '0;
         lag        <= '0;
         lag_valid  <= 1'b0;
         meas_valid <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         lag_cap    <= lag_cap_nx;
         lag_seen   <= lag_seen_nx;
         prev1      <= prev1_nx;
         prev2      <= prev2_nx;
         period     <= period_nx;
         lag        <= lag_nx;
         lag_valid  <= lag_valid_nx;
         meas_valid <= meas_valid_nx;
         timeout    <= timeout_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      lag_cap_nx    = lag_cap;
      lag_seen_nx   = lag_seen;
      prev1_nx      = en ? din1 : prev1;
      prev2_nx      = en ? din2 : prev2;
      period_nx     = period;
      lag_nx        = lag;
      lag_valid_nx  = lag_valid;
      meas_valid_nx = 1'b0;
      timeout_nx    = 1'b0;
      if (en) begin
         if (x1) begin
            // Every channel-1 crossing opens a new period; a coincident
            // channel-2 crossing is a zero lag for that period.
            if (state == ARMED) begin
               period_nx     = cnt + ONE;
               lag_nx        = lag_cap;
               lag_valid_nx  = lag_seen;
               meas_valid_nx = 1'b1;
            end
            state_nx    = ARMED;
            cnt_nx      = '0;
            lag_seen_nx = x2;
            if (x2) lag_cap_nx = '0;
         end else if (state == ARMED) begin
            if (cnt == CNT_LAST) begin
               state_nx    = IDLE;
               cnt_nx      = '0;
               lag_seen_nx = 1'b0;
               timeout_nx  = 1'b1;
            end else begin
               cnt_nx = cnt + ONE;
               if (x2 && !lag_seen) begin
                  lag_cap_nx  = cnt + ONE;
                  lag_seen_nx = 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_sine_meas.sv
// Randomized bench for sine_meas: a crossing-index model predicts each pulse,
// a monitor pops predictions and compares them against the DUT outputs.
module tb_sine_meas;
   localparam int DW  = 8;
   localparam int CW  = 9;
   localparam int MID = 128;
   localparam int MAXD = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [DW-1:0] din1, din2;
   logic [CW-1:0] period, lag;
   logic          meas_valid, lag_valid, timeout;

   sine_meas #(.D_WIDTH(DW), .C_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .en(en), .din1(din1), .din2(din2),
      .period(period), .lag(lag), .meas_valid(meas_valid),
      .lag_valid(lag_valid), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      bit mv;
      bit to;
      int per;
      int lg;
      bit lv;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   done = 0;
   logic [7:0] rom [256];

   // model state: sample indices of crossings rather than counters
   int  sidx, m_last, m_lagcap, m_per, m_lag;
   bit  m_armed, m_x2seen, m_lv;
   int  m_prev1, m_prev2;
   // values last reported by the DUT as seen by the monitor
   int  h_per, h_lag;
   bit  h_lv;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic model_reset();
      sidx = 0; m_last = 0; m_lagcap = 0; m_per = 0; m_lag = 0;
      m_armed = 0; m_x2seen = 0; m_lv = 0;
      m_prev1 = 255; m_prev2 = 255;
      h_per = 0; h_lag = 0; h_lv = 0;
      q.delete();
   endtask

   task automatic push(input bit mv, input bit to);
      exp_t e;
      e.cyc = cyc + 1; e.mv = mv; e.to = to;
      e.per = m_per; e.lg = m_lag; e.lv = m_lv;
      q.push_back(e);
   endtask

   task automatic step(input bit e, input int a, input int b);
      bit x1, x2;
      int d;
      @(negedge clk);
      en = e; din1 = DW'(a); din2 = DW'(b);
      if (e) begin
         x1 = (m_prev1 < MID) && ((a & 255) >= MID);
         x2 = (m_prev2 < MID) && ((b & 255) >= MID);
         m_prev1 = a & 255; m_prev2 = b & 255;
         sidx++;
         d = sidx - m_last;
         if (x1) begin
            if (m_armed) begin
               m_per = d; m_lag = m_lagcap; m_lv = m_x2seen;
               push(1, 0);
            end
            m_armed = 1; m_last = sidx; m_x2seen = x2;
            if (x2) m_lagcap = 0;
         end else if (m_armed && d == MAXD) begin
            m_armed = 0; m_x2seen = 0;
            push(0, 1);
         end else if (m_armed && x2 && !m_x2seen) begin
            m_x2seen = 1; m_lagcap = d;
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst && !done) begin
         if (q.size() != 0 && q[0].cyc == cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (meas_valid !== e.mv || timeout !== e.to || int'(period) != e.per ||
                int'(lag) != e.lg || lag_valid !== e.lv) begin
               errors++;
               $display("FAIL pulse cyc=%0d got mv=%b to=%b per=%0d lag=%0d lv=%b want mv=%b to=%b per=%0d lag=%0d lv=%b",
                        cyc, meas_valid, timeout, period, lag, lag_valid, e.mv, e.to, e.per, e.lg, e.lv);
            end
            h_per = e.per; h_lag = e.lg; h_lv = e.lv;
         end else begin
            checks++;
            if (meas_valid !== 1'b0 || timeout !== 1'b0 || int'(period) != h_per ||
                int'(lag) != h_lag || lag_valid !== h_lv) begin
               errors++;
               $display("FAIL idle cyc=%0d got mv=%b to=%b per=%0d lag=%0d lv=%b want mv=0 to=0 per=%0d lag=%0d lv=%b",
                        cyc, meas_valid, timeout, period, lag, lag_valid, h_per, h_lag, h_lv);
            end
         end
      end
   end

   task automatic check_zero(input string nm);
      checks++;
      if (period !== '0 || lag !== '0 || meas_valid !== 1'b0 || lag_valid !== 1'b0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL %s got per=%0d lag=%0d mv=%b lv=%b to=%b want all 0",
                  nm, period, lag, meas_valid, lag_valid, timeout);
      end
   endtask

   task automatic do_reset(input string nm);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check_zero(nm);
      model_reset();
      @(negedge clk);
      #2 rst = 1'b1;
   endtask

   task automatic run_sine(input int incr, input int off, input int n, input bit tog, input bit z2);
      logic [7:0] ph, p2;
      ph = 8'd0;
      for (int i = 0; i < n; i++) begin
         if (tog) step(0, $urandom_range(255), $urandom_range(255));
         p2 = ph + 8'(off);
         step(1, int'(rom[ph]), z2 ? 0 : int'(rom[p2]));
         ph = ph + 8'(incr);
      end
   endtask

   task automatic run_square(input int per, input int n);
      for (int i = 0; i < n; i++)
         step(1, (i % per) < per / 2 ? 0 : 255, $urandom_range(255));
   endtask

   initial begin
      for (int i = 0; i < 256; i++)
         rom[i] = 8'(128 + $rtoi($floor(127.0 * $sin(6.283185307179586 * i / 256.0) + 0.5)));
      rst = 1'b0; en = 1'b0; din1 = '0; din2 = '0;
      model_reset();
      #12 check_zero("reset");
      @(negedge clk);
      #2 rst = 1'b1;

      run_sine(1, 0, 1024, 0, 0);      // period 256, lag 0 via coincident crossing
      run_sine(1, 64, 1024, 0, 0);     // lag 192
      run_sine(1, 192, 1024, 0, 0);    // lag 64
      run_sine(4, 0, 256, 0, 0);       // period 64
      run_sine(1, 0, 600, 1, 0);       // en toggling
      run_sine(1, 0, 800, 0, 1);       // no channel-2 crossings
      run_sine(1, 64, 300, 0, 0);
      do_reset("reset_mid");
      run_sine(1, 0, 800, 0, 0);
      run_square(MAXD, 3 * MAXD);      // longest reportable period
      run_square(MAXD + 1, 3 * (MAXD + 1)); // one past: timeouts only
      for (int i = 0; i < 400; i++)
         step($urandom_range(3) != 0, $urandom_range(255), $urandom_range(255));
      for (int i = 0; i < 300; i++)    // stall below mid-scale after crossings
         step(1, i < 4 ? (i % 2 ? 200 : 0) : 10, $urandom_range(255));
      step(0, 0, 0);
      repeat (4) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", q.size());
      end
      done = 1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
